// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared command/error types, mode-register defaults and bank indexing
package ddr_pkg;

    typedef enum logic [3:0] {
        CMD_DES, CMD_NOP, CMD_ACT, CMD_MRS, CMD_REF, CMD_PRE, CMD_PREA,
        CMD_RD, CMD_RDA, CMD_WR, CMD_WRA, CMD_ZQCL, CMD_ILL
    } command_type;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ACT_OPEN    = 3'd1,
        ERR_BANK_CLOSED = 3'd2,
        ERR_REF_OPEN    = 3'd3,
        ERR_MRS_OPEN    = 3'd4,
        ERR_ILLEGAL     = 3'd5
    } err_code_e;

    localparam logic [4:0] CL_DEF  = 5'd9;
    localparam logic [4:0] CWL_DEF = 5'd9;
    localparam logic [3:0] BL_DEF  = 4'd8;

    function automatic logic [3:0] bank_index(input logic [1:0] bg, input logic [1:0] ba);
        return {bg, ba};
    endfunction

endpackage

// File: rtl/ddr4_data_window.sv
// rtl/ddr4_data_window.sv - shift-register data-window generator; bit 0 is the live enable
module ddr4_data_window #(
    parameter int MAX_LAT = 32,
    parameter int LAT_W   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LAT_W-1:0] latency,
    input  logic [3:0]       burst_len,
    output logic             en
);

    logic [MAX_LAT-1:0] sr_q, sr_d, run;

    // Run placed at offset `latency` lands in bit 0 exactly `latency` edges later;
    // bits shifted past MAX_LAT-1 are dropped, which truncates long windows.
    always_comb begin
        run  = ((MAX_LAT'(1) << burst_len) - MAX_LAT'(1)) << latency;
        sr_d = (sr_q >> 1) | (start ? run : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign en = sr_q[0];

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// rtl/ddr4_cmd_decoder.sv - DDR4 command/address decoder with mode-register shadow,
// bank tracking, read/write data windows and protocol checks
import ddr_pkg::*;

module ddr4_cmd_decoder #(
    parameter int NUM_BG  = 4,
    parameter int NUM_BA  = 4,
    parameter int MAX_LAT = 32
) (
    input  logic                       CK_t,
    input  logic                       reset,
    input  logic                       cs_n,
    input  logic                       act_n,
    input  logic                       RAS_n_A16,
    input  logic                       CAS_n_A15,
    input  logic                       WE_n_A14,
    input  logic [1:0]                 bg_addr,
    input  logic [1:0]                 ba_addr,
    input  logic                       A17,
    input  logic                       A13,
    input  logic                       A12_BC_n,
    input  logic                       A11,
    input  logic                       A10_AP,
    input  logic [9:0]                 A9_A0,
    output logic                       cmd_valid,
    output command_type                cmd,
    output logic [3:0]                 cmd_bank,
    output logic [13:0]                cmd_row,
    output logic [9:0]                 cmd_col,
    output logic [4:0]                 CL,
    output logic [4:0]                 CWL,
    output logic [4:0]                 AL,
    output logic [3:0]                 BL,
    output logic [NUM_BG*NUM_BA-1:0]   bank_open,
    output logic                       rd_data_en,
    output logic                       wr_data_en,
    output logic                       proto_err,
    output err_code_e                  err_code
);

    localparam int NB = NUM_BG * NUM_BA;

    command_type     cmd_q, cmd_d;
    err_code_e       err_q, err_d;
    logic            cmd_valid_q, proto_err_q;
    logic [3:0]      cmd_bank_q;
    logic [13:0]     cmd_row_q;
    logic [9:0]      cmd_col_q;
    logic [4:0]      cl_q, cwl_q, al_q;
    logic [3:0]      bl_q;
    logic [NB-1:0]   bank_open_q, bank_d;
    logic [3:0]      bank;
    logic [2:0]      mr_sel;
    logic            this_open, any_open, is_rd, is_wr;
    logic            unused_pins;

    assign unused_pins = A17;
    assign bank        = bank_index(bg_addr, ba_addr);
    assign mr_sel      = {bg_addr[0], ba_addr};
    assign this_open   = bank_open_q[bank];
    assign any_open    = |bank_open_q;
    assign is_rd       = (cmd_d == CMD_RD) || (cmd_d == CMD_RDA);
    assign is_wr       = (cmd_d == CMD_WR) || (cmd_d == CMD_WRA);

    always_comb begin
        cmd_d = CMD_DES;
        if (!cs_n) begin
            if (!act_n) begin
                cmd_d = CMD_ACT;
            end else begin
                case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
                    3'b000:  cmd_d = CMD_MRS;
                    3'b001:  cmd_d = CMD_REF;
                    3'b010:  cmd_d = A10_AP ? CMD_PREA : CMD_PRE;
                    3'b101:  cmd_d = A10_AP ? CMD_RDA  : CMD_RD;
                    3'b100:  cmd_d = A10_AP ? CMD_WRA  : CMD_WR;
                    3'b110:  cmd_d = A10_AP ? CMD_ZQCL : CMD_ILL;
                    3'b111:  cmd_d = CMD_NOP;
                    default: cmd_d = CMD_ILL;
                endcase
            end
        end
    end

    // Each command has exactly one applicable check, so codes never compete.
    always_comb begin
        err_d  = ERR_NONE;
        bank_d = bank_open_q;
        case (cmd_d)
            CMD_ACT: begin
                if (this_open) err_d = ERR_ACT_OPEN;
                bank_d[bank] = 1'b1;
            end
            CMD_PRE:  bank_d[bank] = 1'b0;
            CMD_PREA: bank_d = '0;
            CMD_RD, CMD_WR: begin
                if (!this_open) err_d = ERR_BANK_CLOSED;
            end
            CMD_RDA, CMD_WRA: begin
                if (!this_open) err_d = ERR_BANK_CLOSED;
                bank_d[bank] = 1'b0;
            end
            CMD_REF: if (any_open) err_d = ERR_REF_OPEN;
            CMD_MRS: if (any_open) err_d = ERR_MRS_OPEN;
            CMD_ILL: err_d = ERR_ILLEGAL;
            default: ;
        endcase
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            cmd_q       <= CMD_DES;
            cmd_valid_q <= 1'b0;
            cmd_bank_q  <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            bank_open_q <= '0;
            proto_err_q <= 1'b0;
            err_q       <= ERR_NONE;
            cl_q        <= CL_DEF;
            cwl_q       <= CWL_DEF;
            al_q        <= 5'd0;
            bl_q        <= BL_DEF;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= !(cmd_d inside {CMD_DES, CMD_NOP});
            bank_open_q <= bank_d;
            proto_err_q <= (err_d != ERR_NONE);
            err_q       <= err_d;
            if (!(cmd_d inside {CMD_DES, CMD_NOP})) cmd_bank_q <= bank;
            if (cmd_d == CMD_ACT) cmd_row_q <= {A13, A12_BC_n, A11, A10_AP, A9_A0};
            if (is_rd || is_wr)   cmd_col_q <= A9_A0;
            // AL is derived from the CL in effect before this edge.
            if (cmd_d == CMD_MRS) begin
                case (mr_sel)
                    3'd0: begin
                        cl_q <= (A9_A0[6:5] == 2'b00) ? CL_DEF + {3'b000, A9_A0[4:3]} : CL_DEF;
                        bl_q <= (A9_A0[1:0] == 2'b10) ? 4'd4 : BL_DEF;
                    end
                    3'd1: begin
                        case (A9_A0[4:3])
                            2'd1:    al_q <= cl_q - 5'd1;
                            2'd2:    al_q <= cl_q - 5'd2;
                            default: al_q <= 5'd0;
                        endcase
                    end
                    3'd2: cwl_q <= (A9_A0[5:3] == 3'd2) ? 5'd11 : CWL_DEF;
                    default: ;
                endcase
            end
        end
    end

    ddr4_data_window #(.MAX_LAT(MAX_LAT), .LAT_W(6)) u_rd_win (
        .clk       (CK_t),
        .reset     (reset),
        .start     (is_rd && this_open),
        .latency   ({1'b0, al_q} + {1'b0, cl_q}),
        .burst_len ({1'b0, bl_q[3:1]}),
        .en        (rd_data_en)
    );

    ddr4_data_window #(.MAX_LAT(MAX_LAT), .LAT_W(6)) u_wr_win (
        .clk       (CK_t),
        .reset     (reset),
        .start     (is_wr && this_open),
        .latency   ({1'b0, al_q} + {1'b0, cwl_q}),
        .burst_len ({1'b0, bl_q[3:1]}),
        .en        (wr_data_en)
    );

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_bank  = cmd_bank_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign CL        = cl_q;
    assign CWL       = cwl_q;
    assign AL        = al_q;
    assign BL        = bl_q;
    assign bank_open = bank_open_q;
    assign proto_err = proto_err_q;
    assign err_code  = err_q;

endmodule
